// File: rtl/rom_arb_pkg.sv
// Shared defaults, response tag type and helpers for the dual-port ROM arbiter.
package rom_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 3;
  localparam int DW_DEF   = 8;
  localparam int CW_DEF   = 16;
  localparam int IDX_W    = $clog2(NREQ_DEF);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [IDX_W:0] popcount(input logic [NREQ_DEF-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < NREQ_DEF; i++) begin
      n = n + {{IDX_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NREQ_DEF - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational rotating-priority picker that selects up to two winners,
// scanning upward from i_ptr with wraparound.
module rr_pick2
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt1,
  output logic [NREQ-1:0]  o_gnt2,
  output logic             o_vld1,
  output logic             o_vld2,
  output logic [IDX_W-1:0] o_idx1,
  output logic [IDX_W-1:0] o_idx2
);

  int w_pos;

  // The first valid requester in scan order feeds port 1, the second feeds port 2.
  always_comb begin
    w_pos  = 0;
    o_vld1 = 1'b0;
    o_vld2 = 1'b0;
    o_idx1 = '0;
    o_idx2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NREQ;
      if (i_req[w_pos]) begin
        if (!o_vld1) begin
          o_vld1 = 1'b1;
          o_idx1 = IDX_W'(w_pos);
        end else if (!o_vld2) begin
          o_vld2 = 1'b1;
          o_idx2 = IDX_W'(w_pos);
        end
      end
    end
    o_gnt1 = o_vld1 ? (NREQ'(1) << o_idx1) : '0;
    o_gnt2 = o_vld2 ? (NREQ'(1) << o_idx2) : '0;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing an external two-port ROM among NREQ requesters,
// returning one-cycle-latency responses tagged back to each winner.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic               rom_en1,
  output logic               rom_en2,
  output logic [AW-1:0]      rom_addr1,
  output logic [AW-1:0]      rom_addr2,
  input  logic [DW-1:0]      rom_dout1,
  input  logic [DW-1:0]      rom_dout2,
  output logic [CW-1:0]      conflict_cnt
);

  logic [IDX_W-1:0] r_ptr;
  tag_t             r_tag1;
  tag_t             r_tag2;
  logic [CW-1:0]    r_conflict;

  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_gnt1;
  logic [NREQ-1:0]  w_gnt2;
  logic             w_vld1;
  logic             w_vld2;
  logic [IDX_W-1:0] w_idx1;
  logic [IDX_W-1:0] w_idx2;
  logic             w_conflict;

  // Gating with rst_n keeps the ROM quiet and grants off throughout reset.
  assign w_req = req_valid & {NREQ{arb_en & rst_n}};

  rr_pick2 #(.NREQ(NREQ)) u_pick (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_gnt1 (w_gnt1),
    .o_gnt2 (w_gnt2),
    .o_vld1 (w_vld1),
    .o_vld2 (w_vld2),
    .o_idx1 (w_idx1),
    .o_idx2 (w_idx2)
  );

  assign req_ready    = w_gnt1 | w_gnt2;
  assign rom_en1      = w_vld1;
  assign rom_en2      = w_vld2;
  assign rom_addr1    = w_vld1 ? req_addr[w_idx1*AW +: AW] : '0;
  assign rom_addr2    = w_vld2 ? req_addr[w_idx2*AW +: AW] : '0;
  assign w_conflict   = popcount(req_valid) > (IDX_W + 1)'(2);
  assign conflict_cnt = r_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
      r_conflict <= '0;
    end else begin
      r_tag1 <= '{valid: w_vld1, idx: w_idx1};
      r_tag2 <= '{valid: w_vld2, idx: w_idx2};
      // Pointer moves just past the lower-priority winner of this cycle.
      if (w_vld1) begin
        r_ptr <= w_vld2 ? next_idx(w_idx2) : next_idx(w_idx1);
      end
      if (w_conflict && (r_conflict != '1)) begin
        r_conflict <= r_conflict + 1'b1;
      end
    end
  end

  // Tags arrive alongside the ROM's registered data, so steering is purely combinational.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (r_tag1.valid) begin
      rsp_valid[r_tag1.idx]          = 1'b1;
      rsp_data[r_tag1.idx*DW +: DW]  = rom_dout1;
    end
    if (r_tag2.valid) begin
      rsp_valid[r_tag2.idx]          = 1'b1;
      rsp_data[r_tag2.idx*DW +: DW]  = rom_dout2;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a dual-port ROM model holding data = addr + 3.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [11:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rom_en1;
  logic        rom_en2;
  logic [2:0]  rom_addr1;
  logic [2:0]  rom_addr2;
  logic [7:0]  rom_dout1;
  logic [7:0]  rom_dout2;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int fails  = 0;

  rom_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arb_en       (arb_en),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rom_en1      (rom_en1),
    .rom_en2      (rom_en2),
    .rom_addr1    (rom_addr1),
    .rom_addr2    (rom_addr2),
    .rom_dout1    (rom_dout1),
    .rom_dout2    (rom_dout2),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered dual-port ROM: contents are addr + 3, output is 0 when the port is disabled.
  always @(posedge clk) begin
    rom_dout1 <= rom_en1 ? 8'(rom_addr1) + 8'd3 : 8'd0;
    rom_dout2 <= rom_en2 ? 8'(rom_addr2) + 8'd3 : 8'd0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] v, input logic [11:0] a);
    arb_en    = en;
    req_valid = v;
    req_addr  = a;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    arb_en    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
    step();
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if ({rom_en1, rom_en2} !== 2'b00) begin fails++; $display("[TB] FAIL reset_rom_en got %b exp 00", {rom_en1, rom_en2}); end
    checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (conflict_cnt !== 16'h0000) begin fails++; $display("[TB] FAIL reset_conflict got %h exp 0000", conflict_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    applyStimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5});
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL single_ready got %b exp 0001", req_ready); end
    checks++; if (rom_en1 !== 1'b1 || rom_addr1 !== 3'd5) begin fails++; $display("[TB] FAIL single_port1 got en=%b addr=%0d exp en=1 addr=5", rom_en1, rom_addr1); end
    checks++; if (rom_en2 !== 1'b0 || rom_addr2 !== 3'd0) begin fails++; $display("[TB] FAIL single_port2 got en=%b addr=%0d exp en=0 addr=0", rom_en2, rom_addr2); end
    step();
    applyStimulus(1'b1, 4'b1111, {3'd0, 3'd0, 3'd0, 3'd5});
    checks++; if (rsp_valid !== 4'b0001) begin fails++; $display("[TB] FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000_0008) begin fails++; $display("[TB] FAIL single_rsp_data got %h exp 00000008", rsp_data); end
    checks++; if (req_ready !== 4'b0110) begin fails++; $display("[TB] FAIL single_ptr_next got %b exp 0110", req_ready); end
  endtask

  task automatic test_all_four();
    do_reset();
    applyStimulus(1'b1, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
    checks++; if (req_ready !== 4'b0011) begin fails++; $display("[TB] FAIL four_A_ready got %b exp 0011", req_ready); end
    checks++; if (rom_addr1 !== 3'd0 || rom_addr2 !== 3'd1) begin fails++; $display("[TB] FAIL four_A_addr got %0d,%0d exp 0,1", rom_addr1, rom_addr2); end
    step();
    checks++; if (req_ready !== 4'b1100) begin fails++; $display("[TB] FAIL four_B_ready got %b exp 1100", req_ready); end
    checks++; if (rom_addr1 !== 3'd2 || rom_addr2 !== 3'd3) begin fails++; $display("[TB] FAIL four_B_addr got %0d,%0d exp 2,3", rom_addr1, rom_addr2); end
    checks++; if (rsp_valid !== 4'b0011) begin fails++; $display("[TB] FAIL four_A_rsp_valid got %b exp 0011", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000_0403) begin fails++; $display("[TB] FAIL four_A_rsp_data got %h exp 00000403", rsp_data); end
    step();
    checks++; if (rsp_valid !== 4'b1100) begin fails++; $display("[TB] FAIL four_B_rsp_valid got %b exp 1100", rsp_valid); end
    checks++; if (rsp_data !== 32'h0605_0000) begin fails++; $display("[TB] FAIL four_B_rsp_data got %h exp 06050000", rsp_data); end
    checks++; if (req_ready !== 4'b0011) begin fails++; $display("[TB] FAIL four_ptr_wrap got %b exp 0011", req_ready); end
  endtask

  task automatic test_three_rotation();
    int p1 [3] = '{1, 3, 2};
    int p2 [3] = '{2, 1, 3};
    logic [3:0] exp_v;
    logic [31:0] exp_d;
    do_reset();
    applyStimulus(1'b1, 4'b1110, {3'd7, 3'd6, 3'd5, 3'd0});
    for (int k = 0; k < 6; k++) begin
      exp_v = 4'((1 << p1[k%3]) | (1 << p2[k%3]));
      checks++; if (req_ready !== exp_v) begin fails++; $display("[TB] FAIL rot_ready[%0d] got %b exp %b", k, req_ready, exp_v); end
      checks++; if (rom_addr1 !== 3'(p1[k%3] + 4) || rom_addr2 !== 3'(p2[k%3] + 4)) begin fails++; $display("[TB] FAIL rot_addr[%0d] got %0d,%0d exp %0d,%0d", k, rom_addr1, rom_addr2, p1[k%3] + 4, p2[k%3] + 4); end
      step();
      exp_d = '0;
      exp_d[p1[k%3]*8 +: 8] = 8'(p1[k%3] + 7);
      exp_d[p2[k%3]*8 +: 8] = 8'(p2[k%3] + 7);
      checks++; if (rsp_valid !== exp_v || rsp_data !== exp_d) begin fails++; $display("[TB] FAIL rot_rsp[%0d] got %b/%h exp %b/%h", k, rsp_valid, rsp_data, exp_v, exp_d); end
    end
    applyStimulus(1'b1, 4'b0000, '0);
    checks++; if (conflict_cnt !== 16'd6) begin fails++; $display("[TB] FAIL rot_conflict got %0d exp 6", conflict_cnt); end
  endtask

  task automatic test_arb_disable();
    do_reset();
    applyStimulus(1'b0, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL dis_ready got %b exp 0000", req_ready); end
    checks++; if ({rom_en1, rom_en2} !== 2'b00 || rom_addr1 !== 3'd0) begin fails++; $display("[TB] FAIL dis_rom got en=%b%b addr=%0d exp 00/0", rom_en1, rom_en2, rom_addr1); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL dis_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (conflict_cnt !== 16'd1) begin fails++; $display("[TB] FAIL dis_conflict got %0d exp 1", conflict_cnt); end
    applyStimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2});
    step();
    applyStimulus(1'b0, 4'b1111, {3'd0, 3'd0, 3'd0, 3'd2});
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'h0000_0005) begin fails++; $display("[TB] FAIL dis_inflight got %b/%h exp 0001/00000005", rsp_valid, rsp_data); end
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL dis_ready2 got %b exp 0000", req_ready); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    applyStimulus(1'b1, 4'b0100, {3'd0, 3'd7, 3'd0, 3'd0});
    checks++; if (req_ready !== 4'b0100 || rom_addr1 !== 3'd7) begin fails++; $display("[TB] FAIL rst_grant got %b/%0d exp 0100/7", req_ready, rom_addr1); end
    step();
    req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0000 || rsp_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_discard got %b/%h exp 0000/00000000", rsp_valid, rsp_data); end
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1111, {3'd0, 3'd7, 3'd0, 3'd0});
    checks++; if (req_ready !== 4'b0011) begin fails++; $display("[TB] FAIL rst_ptr got %b exp 0011", req_ready); end
    checks++; if (conflict_cnt !== 16'd0) begin fails++; $display("[TB] FAIL rst_conflict got %0d exp 0", conflict_cnt); end
    step();
    checks++; if (rsp_valid !== 4'b0011 || rsp_data !== 32'h0000_0303) begin fails++; $display("[TB] FAIL rst_after got %b/%h exp 0011/00000303", rsp_valid, rsp_data); end
  endtask

  task automatic test_saturation();
    do_reset();
    applyStimulus(1'b1, 4'b0111, {3'd0, 3'd1, 3'd2, 3'd3});
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFE) begin fails++; $display("[TB] FAIL sat_before got %h exp fffe", conflict_cnt); end
    step();
    checks++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_reach got %h exp ffff", conflict_cnt); end
    repeat (5) step();
    checks++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_hold got %h exp ffff", conflict_cnt); end
  endtask

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    test_reset();
    test_single();
    test_all_four();
    test_three_rotation();
    test_arb_disable();
    test_reset_inflight();
    test_saturation();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
